// File: rtl/gfx_cmd_sequencer.sv
// gfx_cmd_sequencer: queued graphics command sequencer driving the VGA text
// interface through an Avalon-MM write master (assert / hold / deassert).
module gfx_cmd_sequencer #(
    parameter int DEPTH        = 8,
    parameter int SWEEP_CYCLES = 76800,
    parameter int SHORT_HOLD   = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [2:0]  CMD_TYPE,
    input  logic [30:0] CMD_DATA,
    output logic        AVM_CS,
    output logic        AVM_WRITE,
    output logic [17:0] AVM_ADDR,
    output logic [31:0] AVM_WRITEDATA,
    output logic [3:0]  AVM_BYTE_EN,
    input  logic        AVM_WAITREQUEST,
    output logic        FRAME_O,
    output logic        BUSY,
    output logic        ERR
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ASSERT   = 2'd1;
    localparam logic [1:0] S_HOLD     = 2'd2;
    localparam logic [1:0] S_DEASSERT = 2'd3;

    localparam logic [2:0] T_FLIP  = 3'd0;
    localparam logic [2:0] T_BOARD = 3'd1;
    localparam logic [2:0] T_STORE = 3'd2;
    localparam logic [2:0] T_WSPR  = 3'd3;
    localparam logic [2:0] T_CLEAR = 3'd4;

    localparam logic [16:0] LD_SWEEP = 17'(SWEEP_CYCLES - 1);
    localparam logic [16:0] LD_SHORT = 17'(SHORT_HOLD - 1);

    logic [33:0] r_mem [DEPTH];
    logic [AW:0] r_wp;
    logic [AW:0] r_rp;
    logic [1:0]  r_state;
    logic [2:0]  r_type;
    logic [30:0] r_data;
    logic [16:0] r_cnt;
    logic        r_frame;
    logic        r_err;

    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic [33:0] w_head;
    logic [2:0]  w_head_type;
    logic        w_legal;
    logic        w_wr;
    logic        w_acc;
    logic [16:0] w_load;
    logic [17:0] w_addr;
    logic [31:0] w_wdata;

    // Extra pointer MSB distinguishes full from empty when indices match.
    assign w_empty     = (r_wp == r_rp);
    assign w_full      = (r_wp[AW] != r_rp[AW]) &&
                         (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_push      = CMD_VALID && !w_full;
    assign w_pop       = (r_state == S_IDLE) && !w_empty;
    assign w_head      = r_mem[r_rp[AW-1:0]];
    assign w_head_type = w_head[33:31];
    assign w_legal     = (w_head_type <= T_CLEAR);

    assign w_wr  = (r_state == S_ASSERT) || (r_state == S_DEASSERT);
    assign w_acc = w_wr && !AVM_WAITREQUEST;

    assign w_load = ((r_type == T_BOARD) || (r_type == T_WSPR)) ?
                    LD_SWEEP : LD_SHORT;

    always_comb begin
        w_addr = 18'h20000;
        case (r_type)
            T_BOARD: w_addr = 18'h20001;
            T_STORE: w_addr = 18'h20002;
            T_WSPR:  w_addr = 18'h20004;
            T_CLEAR: w_addr = 18'h20008;
            default: w_addr = 18'h20000;
        endcase
    end

    always_comb begin
        w_wdata = 32'h0;
        if (r_state == S_ASSERT) begin
            if (r_type == T_FLIP)
                w_wdata = {31'b0, ~r_frame};
            else
                w_wdata = {1'b1, r_data};
        end else if (r_state == S_DEASSERT) begin
            w_wdata = {1'b0, r_data};
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push)
            r_mem[r_wp[AW-1:0]] <= {CMD_TYPE, CMD_DATA};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_state <= S_IDLE;
            r_type  <= T_FLIP;
            r_data  <= '0;
            r_cnt   <= '0;
            r_frame <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_push)
                r_wp <= r_wp + 1'b1;
            if (w_pop)
                r_rp <= r_rp + 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        if (w_legal) begin
                            r_type  <= w_head_type;
                            r_data  <= w_head[30:0];
                            r_state <= S_ASSERT;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_ASSERT: begin
                    if (w_acc) begin
                        if (r_type == T_FLIP) begin
                            r_frame <= ~r_frame;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt   <= w_load;
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (r_cnt == '0)
                        r_state <= S_DEASSERT;
                    else
                        r_cnt <= r_cnt - 1'b1;
                end
                S_DEASSERT: begin
                    if (w_acc)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign CMD_READY     = !w_full;
    assign AVM_CS        = w_wr;
    assign AVM_WRITE     = w_wr;
    assign AVM_ADDR      = w_wr ? w_addr : 18'h0;
    assign AVM_WRITEDATA = w_wdata;
    assign AVM_BYTE_EN   = 4'b1111;
    assign FRAME_O       = r_frame;
    assign BUSY          = (r_state != S_IDLE) || !w_empty;
    assign ERR           = r_err;
endmodule

// File: tb/tb_gfx_cmd_sequencer.sv
// tb_gfx_cmd_sequencer: directed scenarios for the graphics command
// sequencer with hand-computed bus writes, hold lengths and flags.
module tb_gfx_cmd_sequencer;
    localparam int DEPTH = 8;
    localparam int SWEEP = 16;
    localparam int SHORT = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        CMD_VALID = 1'b0;
    logic [2:0]  CMD_TYPE = 3'd0;
    logic [30:0] CMD_DATA = 31'd0;
    logic        AVM_WAITREQUEST = 1'b0;
    logic        CMD_READY;
    logic        AVM_CS;
    logic        AVM_WRITE;
    logic [17:0] AVM_ADDR;
    logic [31:0] AVM_WRITEDATA;
    logic [3:0]  AVM_BYTE_EN;
    logic        FRAME_O;
    logic        BUSY;
    logic        ERR;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    logic [17:0] qa[$];
    logic [31:0] qd[$];
    int          qc[$];

    gfx_cmd_sequencer #(
        .DEPTH(DEPTH),
        .SWEEP_CYCLES(SWEEP),
        .SHORT_HOLD(SHORT)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .CMD_VALID(CMD_VALID),
        .CMD_READY(CMD_READY),
        .CMD_TYPE(CMD_TYPE),
        .CMD_DATA(CMD_DATA),
        .AVM_CS(AVM_CS),
        .AVM_WRITE(AVM_WRITE),
        .AVM_ADDR(AVM_ADDR),
        .AVM_WRITEDATA(AVM_WRITEDATA),
        .AVM_BYTE_EN(AVM_BYTE_EN),
        .AVM_WAITREQUEST(AVM_WAITREQUEST),
        .FRAME_O(FRAME_O),
        .BUSY(BUSY),
        .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // Log every accepted write just before the edge that accepts it.
    always @(negedge CLK) begin
        #4;
        if (AVM_WRITE && !AVM_WAITREQUEST && !RESET) begin
            qa.push_back(AVM_ADDR);
            qd.push_back(AVM_WRITEDATA);
            qc.push_back(cyc);
        end
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic push(input logic [2:0] t, input logic [30:0] d);
        CMD_VALID = 1'b1;
        CMD_TYPE  = t;
        CMD_DATA  = d;
        tick();
        CMD_VALID = 1'b0;
    endtask

    task automatic wait_write(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (AVM_WRITE) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_idle(input int lim, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < lim; n++) begin
            if (!BUSY) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick();
        tick();
        compared++;
        if (CMD_READY !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_ready: got %b want 1", CMD_READY);
        end
        compared++;
        if (AVM_CS !== 1'b0 || AVM_WRITE !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_cs_wr: got %b/%b want 0/0", AVM_CS, AVM_WRITE);
        end
        compared++;
        if (AVM_ADDR !== 18'h0 || AVM_WRITEDATA !== 32'h0) begin
            mismatched++;
            $display("FAIL rst_addr_data: got %h/%h want 0/0",
                     AVM_ADDR, AVM_WRITEDATA);
        end
        compared++;
        if (FRAME_O !== 1'b0 || BUSY !== 1'b0 || ERR !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_flags: got frame=%b busy=%b err=%b want 0",
                     FRAME_O, BUSY, ERR);
        end
        compared++;
        if (AVM_BYTE_EN !== 4'b1111) begin
            mismatched++;
            $display("FAIL rst_byte_en: got %b want 1111", AVM_BYTE_EN);
        end
        RESET = 1'b0;
        tick();
        compared++;
        if (BUSY !== 1'b0 || AVM_WRITE !== 1'b0) begin
            mismatched++;
            $display("FAIL post_rst_idle: got busy=%b wr=%b want 0/0",
                     BUSY, AVM_WRITE);
        end
    endtask

    task automatic test_flip();
        bit ok;
        int base;
        base = qa.size();
        push(3'd0, 31'h0);
        wait_write(ok);
        compared++;
        if (ok !== 1'b1) begin
            mismatched++;
            $display("FAIL flip1_wait: got no write want write");
        end
        compared++;
        if (AVM_ADDR !== 18'h20000 || AVM_WRITEDATA !== 32'h1) begin
            mismatched++;
            $display("FAIL flip1_bus: got %h/%h want 20000/00000001",
                     AVM_ADDR, AVM_WRITEDATA);
        end
        compared++;
        if (FRAME_O !== 1'b0) begin
            mismatched++;
            $display("FAIL flip1_frame_before: got %b want 0", FRAME_O);
        end
        tick();
        compared++;
        if (FRAME_O !== 1'b1 || AVM_WRITE !== 1'b0) begin
            mismatched++;
            $display("FAIL flip1_frame_after: got frame=%b wr=%b want 1/0",
                     FRAME_O, AVM_WRITE);
        end
        push(3'd0, 31'h0);
        wait_write(ok);
        compared++;
        if (ok !== 1'b1 || AVM_WRITEDATA !== 32'h0) begin
            mismatched++;
            $display("FAIL flip2_data: got ok=%b data=%h want 1/00000000",
                     ok, AVM_WRITEDATA);
        end
        tick();
        compared++;
        if (FRAME_O !== 1'b0) begin
            mismatched++;
            $display("FAIL flip2_frame: got %b want 0", FRAME_O);
        end
        wait_idle(50, ok);
        compared++;
        if (qa.size() - base !== 2) begin
            mismatched++;
            $display("FAIL flip_count: got %0d want 2", qa.size() - base);
        end
    endtask

    task automatic test_board();
        bit ok;
        int n;
        push(3'd1, 31'h246);
        wait_write(ok);
        compared++;
        if (ok !== 1'b1 || AVM_ADDR !== 18'h20001 ||
            AVM_WRITEDATA !== 32'h80000246) begin
            mismatched++;
            $display("FAIL board_assert: got ok=%b %h/%h want 1 20001/80000246",
                     ok, AVM_ADDR, AVM_WRITEDATA);
        end
        tick();
        n = 0;
        while (!AVM_WRITE && n < 100) begin
            compared++;
            if (AVM_CS !== 1'b0 || AVM_ADDR !== 18'h0) begin
                mismatched++;
                $display("FAIL board_hold_bus: got cs=%b addr=%h want 0/0",
                         AVM_CS, AVM_ADDR);
            end
            n++;
            tick();
        end
        compared++;
        if (n !== SWEEP) begin
            mismatched++;
            $display("FAIL board_hold_len: got %0d want %0d", n, SWEEP);
        end
        compared++;
        if (AVM_ADDR !== 18'h20001 || AVM_WRITEDATA !== 32'h00000246) begin
            mismatched++;
            $display("FAIL board_deassert: got %h/%h want 20001/00000246",
                     AVM_ADDR, AVM_WRITEDATA);
        end
        tick();
        compared++;
        if (BUSY !== 1'b0 || AVM_WRITE !== 1'b0) begin
            mismatched++;
            $display("FAIL board_done: got busy=%b wr=%b want 0/0",
                     BUSY, AVM_WRITE);
        end
    endtask

    task automatic test_waitreq();
        bit ok;
        int base;
        int hi;
        AVM_WAITREQUEST = 1'b1;
        push(3'd0, 31'h0);
        wait_write(ok);
        compared++;
        if (ok !== 1'b1) begin
            mismatched++;
            $display("FAIL wreq_wait: got no write want write");
        end
        base = qa.size();
        hi = 0;
        for (int k = 0; k < 6; k++) begin
            if (k == 3)
                AVM_WAITREQUEST = 1'b0;
            if (AVM_WRITE) begin
                hi++;
                compared++;
                if (AVM_ADDR !== 18'h20000 || AVM_WRITEDATA !== 32'h1) begin
                    mismatched++;
                    $display("FAIL wreq_stable: got %h/%h want 20000/00000001",
                             AVM_ADDR, AVM_WRITEDATA);
                end
            end
            tick();
        end
        compared++;
        if (hi !== 4) begin
            mismatched++;
            $display("FAIL wreq_high_cycles: got %0d want 4", hi);
        end
        compared++;
        if (qa.size() - base !== 1) begin
            mismatched++;
            $display("FAIL wreq_accepts: got %0d want 1", qa.size() - base);
        end
        compared++;
        if (FRAME_O !== 1'b1) begin
            mismatched++;
            $display("FAIL wreq_frame: got %b want 1", FRAME_O);
        end
    endtask

    task automatic test_fifo_full();
        bit ok;
        int base;
        logic [17:0] ea;
        push(3'd1, 31'h1000);
        wait_write(ok);
        compared++;
        if (ok !== 1'b1) begin
            mismatched++;
            $display("FAIL full_board_wait: got no write want write");
        end
        tick();
        base = qa.size();
        for (int i = 0; i < 8; i++) begin
            CMD_VALID = 1'b1;
            CMD_TYPE  = (i % 2 == 0) ? 3'd2 : 3'd4;
            CMD_DATA  = 31'(i + 1);
            compared++;
            if (CMD_READY !== 1'b1) begin
                mismatched++;
                $display("FAIL full_ready_%0d: got 0 want 1", i);
            end
            tick();
        end
        compared++;
        if (CMD_READY !== 1'b0) begin
            mismatched++;
            $display("FAIL full_ready_low: got %b want 0", CMD_READY);
        end
        CMD_TYPE = 3'd2;
        CMD_DATA = 31'h1FF;
        tick();
        CMD_VALID = 1'b0;
        compared++;
        if (CMD_READY !== 1'b0) begin
            mismatched++;
            $display("FAIL full_still_full: got %b want 0", CMD_READY);
        end
        wait_idle(2000, ok);
        compared++;
        if (ok !== 1'b1) begin
            mismatched++;
            $display("FAIL full_idle_timeout: got busy want idle");
        end
        compared++;
        if (qa.size() - base !== 17) begin
            mismatched++;
            $display("FAIL full_write_count: got %0d want 17",
                     qa.size() - base);
        end
        if (qa.size() >= base + 17) begin
            compared++;
            if (qa[base] !== 18'h20001 || qd[base] !== 32'h00001000) begin
                mismatched++;
                $display("FAIL full_board_end: got %h/%h want 20001/00001000",
                         qa[base], qd[base]);
            end
            for (int i = 0; i < 8; i++) begin
                ea = (i % 2 == 0) ? 18'h20002 : 18'h20008;
                compared++;
                if (qa[base+1+2*i] !== ea ||
                    qd[base+1+2*i] !== {1'b1, 31'(i + 1)} ||
                    qa[base+2+2*i] !== ea ||
                    qd[base+2+2*i] !== {1'b0, 31'(i + 1)}) begin
                    mismatched++;
                    $display("FAIL full_order_%0d: got %h/%h %h/%h want %h",
                             i, qa[base+1+2*i], qd[base+1+2*i],
                             qa[base+2+2*i], qd[base+2+2*i], ea);
                end
            end
        end
    endtask

    task automatic test_illegal();
        int base;
        int errs;
        int n;
        base = qa.size();
        push(3'd6, 31'h7);
        push(3'd2, 31'h55);
        errs = 0;
        for (n = 0; n < 200; n++) begin
            if (ERR)
                errs++;
            if (!BUSY)
                break;
            tick();
        end
        compared++;
        if (n >= 200) begin
            mismatched++;
            $display("FAIL ill_timeout: got busy want idle");
        end
        compared++;
        if (errs !== 1) begin
            mismatched++;
            $display("FAIL ill_err_pulse: got %0d cycles want 1", errs);
        end
        compared++;
        if (qa.size() - base !== 2) begin
            mismatched++;
            $display("FAIL ill_write_count: got %0d want 2", qa.size() - base);
        end
        if (qa.size() >= base + 2) begin
            compared++;
            if (qa[base] !== 18'h20002 || qd[base] !== 32'h80000055 ||
                qa[base+1] !== 18'h20002 || qd[base+1] !== 32'h00000055) begin
                mismatched++;
                $display("FAIL ill_store_bus: got %h/%h %h/%h want 20002",
                         qa[base], qd[base], qa[base+1], qd[base+1]);
            end
            compared++;
            if (qc[base+1] - qc[base] !== SHORT + 1) begin
                mismatched++;
                $display("FAIL ill_store_spacing: got %0d want %0d",
                         qc[base+1] - qc[base], SHORT + 1);
            end
        end
    endtask

    task automatic test_reset_abort();
        bit ok;
        int base;
        push(3'd3, 31'h123);
        wait_write(ok);
        compared++;
        if (ok !== 1'b1 || AVM_ADDR !== 18'h20004 ||
            AVM_WRITEDATA !== 32'h80000123) begin
            mismatched++;
            $display("FAIL abort_assert: got ok=%b %h/%h want 1 20004/80000123",
                     ok, AVM_ADDR, AVM_WRITEDATA);
        end
        tick();
        tick();
        tick();
        compared++;
        if (AVM_WRITE !== 1'b0 || BUSY !== 1'b1 || FRAME_O !== 1'b1) begin
            mismatched++;
            $display("FAIL abort_in_hold: got wr=%b busy=%b frame=%b want 0/1/1",
                     AVM_WRITE, BUSY, FRAME_O);
        end
        base = qa.size();
        RESET = 1'b1;
        tick();
        compared++;
        if (AVM_CS !== 1'b0 || AVM_WRITE !== 1'b0 || AVM_ADDR !== 18'h0 ||
            AVM_WRITEDATA !== 32'h0) begin
            mismatched++;
            $display("FAIL abort_bus: got cs=%b wr=%b %h/%h want 0",
                     AVM_CS, AVM_WRITE, AVM_ADDR, AVM_WRITEDATA);
        end
        compared++;
        if (FRAME_O !== 1'b0 || BUSY !== 1'b0 || ERR !== 1'b0 ||
            CMD_READY !== 1'b1) begin
            mismatched++;
            $display("FAIL abort_flags: got f=%b b=%b e=%b r=%b want 0/0/0/1",
                     FRAME_O, BUSY, ERR, CMD_READY);
        end
        RESET = 1'b0;
        for (int i = 0; i < 40; i++)
            tick();
        compared++;
        if (qa.size() !== base || BUSY !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_no_deassert: got %0d writes busy=%b want 0/0",
                     qa.size() - base, BUSY);
        end
    endtask

    initial begin
        test_reset();
        test_flip();
        test_board();
        test_waitreq();
        test_fifo_full();
        test_illegal();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule

// File: doc/gfx_cmd_sequencer.md
GFX_CMD_SEQUENCER -- requirements
Module: gfx_cmd_sequencer

Interface
REQ-001 Parameter DEPTH, default 8, command FIFO entries (power of two).
REQ-002 Parameter SWEEP_CYCLES, default 76800, hold time for board/sprite-write commands (one full 320x240 write sweep).
REQ-003 Parameter SHORT_HOLD, default 4, hold time for store/clear sprite commands.
REQ-004 CLK  in  1  system clock, 50 MHz, shared with the VGA text interface.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 CMD_VALID  in  1  command offered.
REQ-007 CMD_READY  out  1  FIFO can accept; high iff FIFO not full.
REQ-008 CMD_TYPE  in  3  0=FLIP, 1=BOARD, 2=STORE_SPRITE, 3=WRITE_SPRITE, 4=CLEAR_SPRITE, 5-7 illegal.
REQ-009 CMD_DATA  in  31  payload, placed in write data bits [30:0].
REQ-010 AVM_CS, AVM_WRITE  out  1 each  Avalon-MM master chip select / write, toward the VGA interface.
REQ-011 AVM_ADDR  out  18  slave word address.
REQ-012 AVM_WRITEDATA  out  32  write data.
REQ-013 AVM_BYTE_EN  out  4  always 4'b1111.
REQ-014 AVM_WAITREQUEST  in  1  slave stall.
REQ-015 FRAME_O  out  1  currently displayed buffer index.
REQ-016 BUSY  out  1  high when state is not IDLE or FIFO is not empty.
REQ-017 ERR  out  1  one-cycle pulse on illegal command pop.

Function
REQ-018 Push when CMD_VALID && CMD_READY stores {CMD_TYPE, CMD_DATA}; with the FIFO full, a push is refused even if a pop occurs in the same cycle.
REQ-019 Simultaneous push and pop with the FIFO not full: occupancy unchanged, order preserved.
REQ-020 States: IDLE, ASSERT, HOLD, DEASSERT.
REQ-021 IDLE with FIFO non-empty: pop the head; next cycle enter ASSERT (legal type) or stay in IDLE with ERR pulsed (illegal type, no bus activity).
REQ-022 Address map: FLIP 0x20000, BOARD 0x20001, STORE 0x20002, WRITE_SPRITE 0x20004, CLEAR 0x20008.
REQ-023 ASSERT: AVM_CS=AVM_WRITE=1, AVM_WRITEDATA={1'b1, CMD_DATA}; FLIP instead drives {31'b0, ~FRAME_O}.
REQ-024 A write is accepted in the cycle with AVM_WRITE && !AVM_WAITREQUEST; address and data stay stable until acceptance.
REQ-025 FLIP acceptance: FRAME_O toggles next cycle; return to IDLE.
REQ-026 Non-FLIP acceptance: load a 17-bit hold counter with SWEEP_CYCLES-1 (BOARD, WRITE_SPRITE) or SHORT_HOLD-1 (STORE, CLEAR); enter HOLD.
REQ-027 HOLD: bus idle (CS=WRITE=0); decrement each cycle; at 0 enter DEASSERT (exactly N idle cycles).
REQ-028 DEASSERT: write same address with data {1'b0, CMD_DATA}; on acceptance return to IDLE.
REQ-029 Minimum spacing from one IDLE pop to the next is 1 + N + 2 cycles with zero wait states.
REQ-030 AVM_WAITREQUEST ignored when AVM_WRITE=0; one write per accepted transfer, no duplicates.
REQ-031 Commands execute strictly in FIFO order; no command overlaps another.

Reset
REQ-032 RESET: state=IDLE, FIFO flushed, CMD_READY=1, AVM_CS=AVM_WRITE=0, AVM_ADDR=0, AVM_WRITEDATA=0, FRAME_O=0, BUSY=0, ERR=0, counter=0.
REQ-033 RESET mid-command aborts immediately; no DEASSERT write is issued.

Verification
REQ-034 Reset, push FLIP, zero wait -> one write addr 0x20000 data 0x00000001; FRAME_O=1 next cycle; second FLIP writes 0x00000000.
REQ-035 BOARD data 0x0000_0246, SWEEP_CYCLES=16 -> write 0x20001/0x80000246, exactly 16 idle cycles, write 0x20001/0x00000246, BUSY low after.
REQ-036 AVM_WAITREQUEST held 3 cycles in ASSERT -> AVM_WRITE high 4 cycles, addr/data stable, single acceptance.
REQ-037 Push 9 commands back-to-back, DEPTH=8 -> CMD_READY low after 8th (first not yet popped); 9th refused; accepted commands execute in order.
REQ-038 CMD_TYPE=6 followed by STORE -> ERR one-cycle pulse, no bus write for type 6; STORE to 0x20002 with SHORT_HOLD=4 idle cycles.
REQ-039 RESET asserted during HOLD of WRITE_SPRITE -> next cycle outputs at reset values, no further writes.
